// File: rtl/mem_wait_injector.sv
// Wait-state injector between the picorv32 native memory port and a memory model.
// One request is handled at a time: accept, N wait cycles, strobe, data, ready.
module mem_wait_injector #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_rand_en,
    input  logic [3:0]            cfg_wait,
    input  logic                  core_mem_valid,
    input  logic                  core_mem_instr,
    input  logic [ADDR_W-1:0]     core_mem_addr,
    input  logic [DATA_W-1:0]     core_mem_wdata,
    input  logic [DATA_W/8-1:0]   core_mem_wstrb,
    output logic                  core_mem_ready,
    output logic [DATA_W-1:0]     core_mem_rdata,
    output logic                  m_read,
    output logic                  m_write,
    output logic                  m_instr,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic [31:0]           txn_count,
    output logic                  proto_err
);

    localparam int          STRB_W = DATA_W / 8;
    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DATA,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [3:0]  r_wait_cnt;

    logic [15:0] w_lfsr_next;
    logic [3:0]  w_wait_n;
    logic        w_req_changed;
    logic        w_in_flight;
    logic        w_core_is_read;
    logic        w_latched_is_read;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_comb begin
        w_lfsr_next = {1'b0, r_lfsr[15:1]};
        if (r_lfsr[0]) begin
            w_lfsr_next = w_lfsr_next ^ 16'hB400;
        end
        w_wait_n          = cfg_rand_en ? (r_lfsr[3:0] & cfg_wait) : cfg_wait;
        w_core_is_read    = (core_mem_wstrb == {STRB_W{1'b0}});
        w_latched_is_read = (m_wstrb == {STRB_W{1'b0}});
        w_in_flight       = (r_state == S_WAIT) || (r_state == S_ISSUE) || (r_state == S_DATA);
        w_req_changed     = !core_mem_valid
                          || (core_mem_addr  != m_addr)
                          || (core_mem_wdata != m_wdata)
                          || (core_mem_wstrb != m_wstrb);
    end

    // Outputs are set on entry to the state they belong to, so the strobe is
    // visible during ISSUE and ready during RESP; the core drops valid while
    // we are in RESP, before IDLE samples it again.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_lfsr         <= SEED;
            r_wait_cnt     <= 4'd0;
            core_mem_ready <= 1'b0;
            core_mem_rdata <= {DATA_W{1'b0}};
            m_read         <= 1'b0;
            m_write        <= 1'b0;
            m_instr        <= 1'b0;
            m_addr         <= {ADDR_W{1'b0}};
            m_wdata        <= {DATA_W{1'b0}};
            m_wstrb        <= {STRB_W{1'b0}};
            txn_count      <= 32'd0;
            proto_err      <= 1'b0;
        end else begin
            m_read         <= 1'b0;
            m_write        <= 1'b0;
            core_mem_ready <= 1'b0;

            if (w_in_flight && w_req_changed) begin
                proto_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (core_mem_valid) begin
                        m_instr <= core_mem_instr;
                        m_addr  <= core_mem_addr;
                        m_wdata <= core_mem_wdata;
                        m_wstrb <= core_mem_wstrb;
                        r_lfsr  <= w_lfsr_next;
                        if (w_wait_n != 4'd0) begin
                            r_wait_cnt <= w_wait_n;
                            r_state    <= S_WAIT;
                        end else begin
                            m_read  <= w_core_is_read;
                            m_write <= !w_core_is_read;
                            r_state <= S_ISSUE;
                        end
                    end
                end

                S_WAIT: begin
                    if (r_wait_cnt == 4'd1) begin
                        r_wait_cnt <= 4'd0;
                        m_read     <= w_latched_is_read;
                        m_write    <= !w_latched_is_read;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end

                S_ISSUE: begin
                    r_state <= S_DATA;
                end

                // Memory data is valid during DATA; capture it at the exit edge.
                S_DATA: begin
                    if (w_latched_is_read) begin
                        core_mem_rdata <= m_rdata;
                    end
                    core_mem_ready <= 1'b1;
                    if (txn_count != 32'hFFFF_FFFF) begin
                        txn_count <= txn_count + 32'd1;
                    end
                    r_state <= S_RESP;
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wait_injector.sv
// Directed bench for mem_wait_injector with a small byte-strobed memory model.
// Cycle numbering: the accept edge is cycle 0; cycle k is observed #1 after edge k-1.
module tb_mem_wait_injector;

    logic        clk;
    logic        resetn;
    logic        cfgRandEn;
    logic [3:0]  cfgWait;
    logic        coreValid;
    logic        coreInstr;
    logic [31:0] coreAddr;
    logic [31:0] coreWdata;
    logic [3:0]  coreWstrb;
    logic        coreReady;
    logic [31:0] coreRdata;
    logic        mRead;
    logic        mWrite;
    logic        mInstr;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mWstrb;
    logic [31:0] mRdata;
    logic [31:0] txnCount;
    logic        protoErr;

    int checkCount = 0;
    int passCount  = 0;
    int expTxn     = 0;

    mem_wait_injector #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_rand_en   (cfgRandEn),
        .cfg_wait      (cfgWait),
        .core_mem_valid(coreValid),
        .core_mem_instr(coreInstr),
        .core_mem_addr (coreAddr),
        .core_mem_wdata(coreWdata),
        .core_mem_wstrb(coreWstrb),
        .core_mem_ready(coreReady),
        .core_mem_rdata(coreRdata),
        .m_read        (mRead),
        .m_write       (mWrite),
        .m_instr       (mInstr),
        .m_addr        (mAddr),
        .m_wdata       (mWdata),
        .m_wstrb       (mWstrb),
        .m_rdata       (mRdata),
        .txn_count     (txnCount),
        .proto_err     (protoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten words read back a fixed pattern, except 0x100.
    logic [31:0]  mem [0:255];
    logic [255:0] written = '0;

    function automatic logic [31:0] defaultWord(input logic [7:0] idx);
        return (idx == 8'd64) ? 32'hDEADBEEF : (32'hC0DE0000 | {24'd0, idx});
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] strb);
        logic [31:0] res;
        res = oldW;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = newW[8*b +: 8];
        end
        return res;
    endfunction

    always @(posedge clk) begin
        if (mRead) begin
            mRdata <= written[mAddr[9:2]] ? mem[mAddr[9:2]] : defaultWord(mAddr[9:2]);
        end
        if (mWrite) begin
            mem[mAddr[9:2]]     <= mergeBytes(written[mAddr[9:2]] ? mem[mAddr[9:2]] : defaultWord(mAddr[9:2]),
                                              mWdata, mWstrb);
            written[mAddr[9:2]] <= 1'b1;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one core request and follows it to its ready pulse.
    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic instr, input logic randEn,
                                 input logic [3:0] waitCfg, input int expN, input logic [31:0] expRdata,
                                 input int dropAt, input logic expProto);
        int          readyCycle;
        int          strobeCycle;
        int          strobeCount;
        int          otherCount;
        int          bothCount;
        logic        isWrite;
        logic [31:0] seenRdata;
        logic [31:0] seenTxn;
        logic [31:0] seenAddr;
        logic [3:0]  seenStrb;
        logic        seenProto;
        logic        seenInstr;
        isWrite     = (wstrb != 4'h0);
        readyCycle  = -1;
        strobeCycle = -1;
        strobeCount = 0;
        otherCount  = 0;
        bothCount   = 0;
        seenRdata   = '0;
        seenTxn     = '0;
        seenAddr    = '0;
        seenStrb    = '0;
        seenProto   = 1'b0;
        seenInstr   = 1'b0;
        if (expTxn < 32'hFFFF_FFFF) expTxn++;

        @(negedge clk);
        coreAddr  = addr;
        coreWdata = wdata;
        coreWstrb = wstrb;
        coreInstr = instr;
        cfgRandEn = randEn;
        cfgWait   = waitCfg;
        coreValid = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == dropAt) coreValid = 1'b0;
            if (mRead && mWrite) bothCount++;
            if (isWrite ? mWrite : mRead) begin
                strobeCount++;
                if (strobeCycle < 0) strobeCycle = c;
            end
            if (isWrite ? mRead : mWrite) otherCount++;
            if (coreReady) begin
                readyCycle = c;
                seenRdata  = coreRdata;
                seenTxn    = txnCount;
                seenAddr   = mAddr;
                seenStrb   = mWstrb;
                seenProto  = protoErr;
                seenInstr  = mInstr;
                coreValid  = 1'b0;
                break;
            end
        end

        checkOutput({tag, ".readyCycle"},  readyCycle,  3 + expN);
        checkOutput({tag, ".strobeCycle"}, strobeCycle, 1 + expN);
        checkOutput({tag, ".strobeCount"}, strobeCount, 1);
        checkOutput({tag, ".otherStrobe"}, otherCount,  0);
        checkOutput({tag, ".bothStrobe"},  bothCount,   0);
        checkOutput({tag, ".rdata"},       seenRdata,   expRdata);
        checkOutput({tag, ".txnCount"},    seenTxn,     expTxn);
        checkOutput({tag, ".mAddr"},       seenAddr,    addr);
        checkOutput({tag, ".mWstrb"},      {28'd0, seenStrb},  {28'd0, wstrb});
        checkOutput({tag, ".mInstr"},      {31'd0, seenInstr}, {31'd0, instr});
        checkOutput({tag, ".protoErr"},    {31'd0, seenProto}, {31'd0, expProto});

        @(posedge clk);
        #1;
        checkOutput({tag, ".readyLow"}, {31'd0, coreReady}, 32'd0);
    endtask

    int rstStrobes;

    initial begin
        resetn    = 1'b0;
        cfgRandEn = 1'b0;
        cfgWait   = 4'd0;
        coreValid = 1'b0;
        coreInstr = 1'b0;
        coreAddr  = '0;
        coreWdata = '0;
        coreWstrb = '0;
        rstStrobes = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.ctrl", {27'd0, coreReady, mRead, mWrite, mInstr, protoErr}, 32'd0);
        checkOutput("reset.txn", txnCount, 32'd0);
        checkOutput("reset.rdata", coreRdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Random waits from seed 0xACE1: masks give N=1, then 0xE270 -> 0, then 0x7138 -> 8.
        applyStimulus("rand0", 32'h200, 32'h0, 4'h0, 1'b1, 1'b1, 4'hF, 1, 32'hC0DE0080, -1, 1'b0);
        applyStimulus("rand1", 32'h204, 32'h0, 4'h0, 1'b0, 1'b1, 4'hF, 0, 32'hC0DE0081, -1, 1'b0);
        applyStimulus("rand2", 32'h20,  32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 4'hF, 8, 32'hC0DE0081, -1, 1'b0);

        applyStimulus("read0", 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 4'd0, 0, 32'hDEADBEEF, -1, 1'b0);
        applyStimulus("write5", 32'h10004, 32'h12345678, 4'b0011, 1'b0, 1'b0, 4'd5, 5, 32'hDEADBEEF, -1, 1'b0);

        // Valid dropped in the first WAIT cycle; the transaction still completes.
        applyStimulus("dropValid", 32'h300, 32'h0, 4'h0, 1'b0, 1'b0, 4'd3, 3, 32'hC0DE00C0, 1, 1'b1);
        applyStimulus("sticky", 32'h104, 32'h0, 4'h0, 1'b0, 1'b0, 4'd2, 2, 32'hC0DE0041, -1, 1'b1);

        // Reset in the middle of a wait period.
        @(negedge clk);
        coreAddr  = 32'h400;
        coreWstrb = 4'h0;
        cfgRandEn = 1'b0;
        cfgWait   = 4'd3;
        coreValid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midRst.ctrl", {23'd0, coreReady, mRead, mWrite, mInstr, protoErr, mWstrb}, 32'd0);
        checkOutput("midRst.txn", txnCount, 32'd0);
        checkOutput("midRst.addr", mAddr, 32'd0);
        checkOutput("midRst.rdata", coreRdata, 32'd0);
        coreValid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mRead || mWrite || coreReady) rstStrobes++;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mRead || mWrite || coreReady) rstStrobes++;
        end
        checkOutput("midRst.noStrobe", rstStrobes, 0);
        expTxn = 0;

        applyStimulus("postRst", 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 4'd0, 0, 32'hC0DE0010, -1, 1'b0);

        // Back-to-back reads; the first returns the bytes written earlier.
        applyStimulus("b2b0", 32'h10004, 32'h0, 4'h0, 1'b0, 1'b0, 4'd0, 0, 32'hC0DE5678, -1, 1'b0);
        applyStimulus("b2b1", 32'h100,   32'h0, 4'h0, 1'b0, 1'b0, 4'd0, 0, 32'hDEADBEEF, -1, 1'b0);
        applyStimulus("b2b2", 32'h8,     32'h0, 4'h0, 1'b1, 1'b0, 4'd1, 1, 32'hC0DE0002, -1, 1'b0);
        checkOutput("final.txn", txnCount, 32'd4);
        checkOutput("final.proto", {31'd0, protoErr}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
